// File: rtl/d_unit.sv
// Decode stage of a five-stage MIPS-subset pipeline: instruction decode,
// 32x32 register file with write-through, M-stage forwarding, Tuse/Tnew
// hazard detection, branch/jump resolution and the D/E pipeline register.
module d_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IRD,
  input  logic [31:0] PC4D,
  input  logic        RegWriteW,
  input  logic [4:0]  A3W,
  input  logic [31:0] WDW,
  input  logic [4:0]  WriteRegE,
  input  logic [1:0]  TnewE,
  input  logic [4:0]  WriteRegM,
  input  logic [1:0]  TnewM,
  input  logic [31:0] FwdDataM,
  output logic [31:0] NPC,
  output logic [2:0]  PCsrc,
  output logic        Branch,
  output logic [31:0] RS_D_OUT,
  output logic [31:0] RT_D_OUT,
  output logic        PauseF,
  output logic        PauseD,
  output logic [31:0] IRE,
  output logic [31:0] PC4E,
  output logic [31:0] RSE,
  output logic [31:0] RTE,
  output logic [31:0] EXTE
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [2:0] SRC_PC4 = 3'd0;
  localparam logic [2:0] SRC_BR  = 3'd1;
  localparam logic [2:0] SRC_J   = 3'd2;
  localparam logic [2:0] SRC_JR  = 3'd3;

  // A used operand stalls when a producer in E or M still needs more cycles
  // than this instruction can wait before consuming the value.
  function automatic logic hazard(input logic       used,
                                  input logic [4:0] src,
                                  input logic [1:0] tuse,
                                  input logic [4:0] wr_e,
                                  input logic [1:0] tnew_e,
                                  input logic [4:0] wr_m,
                                  input logic [1:0] tnew_m);
    logic hit;
    hit = 1'b0;
    if (used && (src != 5'd0)) begin
      if ((src == wr_e) && (tnew_e > tuse)) hit = 1'b1;
      if ((src == wr_m) && (tnew_m > tuse)) hit = 1'b1;
    end
    return hit;
  endfunction

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic        is_rtype;
  logic        is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw;
  logic        is_beq, is_j, is_jal;
  logic        use_rs, use_rt;
  logic [1:0]  tuse_rs, tuse_rt;
  logic        stall;
  logic [31:0] rf_q [32];
  logic [31:0] rs_rf, rt_rf;
  logic signed [31:0] imm_sx;
  logic [31:0] ext;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] ire_d, pc4e_d, rse_d, rte_d, exte_d;
  logic [31:0] ire_q, pc4e_q, rse_q, rte_q, exte_q;

  // Field extraction and opcode decode; unknown encodings decode to nothing.
  always_comb begin
    op       = IRD[31:26];
    rs       = IRD[25:21];
    rt       = IRD[20:16];
    imm      = IRD[15:0];
    funct    = IRD[5:0];
    is_rtype = (op == OP_RTYPE) && (IRD[10:6] == 5'd0);
    is_addu  = is_rtype && (funct == FN_ADDU);
    is_subu  = is_rtype && (funct == FN_SUBU);
    is_jr    = is_rtype && (funct == FN_JR);
    is_ori   = (op == OP_ORI);
    is_lui   = (op == OP_LUI);
    is_lw    = (op == OP_LW);
    is_sw    = (op == OP_SW);
    is_beq   = (op == OP_BEQ);
    is_j     = (op == OP_J);
    is_jal   = (op == OP_JAL);
  end

  // Operand usage and how many cycles each operand can wait (Tuse).
  always_comb begin
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    tuse_rs = 2'd0;
    tuse_rt = 2'd0;
    if (is_beq) begin
      use_rs = 1'b1;
      use_rt = 1'b1;
    end else if (is_jr) begin
      use_rs = 1'b1;
    end else if (is_addu || is_subu) begin
      use_rs  = 1'b1;
      use_rt  = 1'b1;
      tuse_rs = 2'd1;
      tuse_rt = 2'd1;
    end else if (is_ori || is_lw) begin
      use_rs  = 1'b1;
      tuse_rs = 2'd1;
    end else if (is_sw) begin
      use_rs  = 1'b1;
      use_rt  = 1'b1;
      tuse_rs = 2'd1;
      tuse_rt = 2'd2;
    end
  end

  // Register-file read with same-cycle write-through, then M-stage forwarding.
  always_comb begin
    rs_rf = 32'd0;
    rt_rf = 32'd0;
    if (rs != 5'd0) rs_rf = (RegWriteW && (A3W == rs)) ? WDW : rf_q[rs];
    if (rt != 5'd0) rt_rf = (RegWriteW && (A3W == rt)) ? WDW : rf_q[rt];
    RS_D_OUT = ((rs != 5'd0) && (rs == WriteRegM) && (TnewM == 2'd0)) ? FwdDataM : rs_rf;
    RT_D_OUT = ((rt != 5'd0) && (rt == WriteRegM) && (TnewM == 2'd0)) ? FwdDataM : rt_rf;
  end

  // Stall request, shared by the fetch and decode sides.
  always_comb begin
    stall  = hazard(use_rs, rs, tuse_rs, WriteRegE, TnewE, WriteRegM, TnewM) ||
             hazard(use_rt, rt, tuse_rt, WriteRegE, TnewE, WriteRegM, TnewM);
    PauseF = stall;
    PauseD = stall;
  end

  // Immediate extension and branch/jump target arithmetic.
  always_comb begin
    imm_sx = {{16{imm[15]}}, imm};
    ext    = 32'd0;
    if (is_ori) ext = {16'd0, imm};
    else if (is_lui) ext = {imm, 16'd0};
    else if (is_lw || is_sw || is_beq) ext = imm_sx;
    br_tgt = PC4D + {imm_sx[29:0], 2'b00};
    j_tgt  = {PC4D[31:28], IRD[25:0], 2'b00};
  end

  // Next-PC selection; a stalled instruction redirects nothing.
  always_comb begin
    NPC    = 32'd0;
    PCsrc  = SRC_PC4;
    Branch = 1'b0;
    if (!stall) begin
      if (is_beq) begin
        NPC    = br_tgt;
        PCsrc  = SRC_BR;
        Branch = (RS_D_OUT == RT_D_OUT);
      end else if (is_j || is_jal) begin
        NPC   = j_tgt;
        PCsrc = SRC_J;
      end else if (is_jr) begin
        NPC   = RS_D_OUT;
        PCsrc = SRC_JR;
      end
    end
  end

  // D/E next state: pass the decoded instruction or insert a bubble.
  always_comb begin
    ire_d  = stall ? 32'd0 : IRD;
    pc4e_d = stall ? 32'd0 : PC4D;
    rse_d  = stall ? 32'd0 : RS_D_OUT;
    rte_d  = stall ? 32'd0 : RT_D_OUT;
    exte_d = stall ? 32'd0 : ext;
  end

  // Register file: reset clears every entry and wins over write-back.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (RegWriteW && (A3W != 5'd0)) begin
      rf_q[A3W] <= WDW;
    end
  end

  // ---- D/E pipeline register boundary ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ire_q  <= 32'd0;
      pc4e_q <= 32'd0;
      rse_q  <= 32'd0;
      rte_q  <= 32'd0;
      exte_q <= 32'd0;
    end else begin
      ire_q  <= ire_d;
      pc4e_q <= pc4e_d;
      rse_q  <= rse_d;
      rte_q  <= rte_d;
      exte_q <= exte_d;
    end
  end

  assign IRE  = ire_q;
  assign PC4E = pc4e_q;
  assign RSE  = rse_q;
  assign RTE  = rte_q;
  assign EXTE = exte_q;

endmodule

// File: tb/tb_d_unit.sv
// Self-checking bench for d_unit: combinational decode outputs are checked
// directly, D/E register contents go through a scoreboard queue.
module tb_d_unit;

  localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] IRD, PC4D, WDW, FwdDataM;
  logic        RegWriteW;
  logic [4:0]  A3W, WriteRegE, WriteRegM;
  logic [1:0]  TnewE, TnewM;
  logic [31:0] NPC, RS_D_OUT, RT_D_OUT, IRE, PC4E, RSE, RTE, EXTE;
  logic [2:0]  PCsrc;
  logic        Branch, PauseF, PauseD;

  typedef struct packed {
    logic [31:0] ire;
    logic [31:0] pc4e;
    logic [31:0] rse;
    logic [31:0] rte;
    logic [31:0] exte;
  } de_t;

  de_t sbq[$];
  int  nchk = 0;
  int  nerr = 0;

  d_unit dut (
    .Clk(Clk), .Reset(Reset), .IRD(IRD), .PC4D(PC4D),
    .RegWriteW(RegWriteW), .A3W(A3W), .WDW(WDW),
    .WriteRegE(WriteRegE), .TnewE(TnewE),
    .WriteRegM(WriteRegM), .TnewM(TnewM), .FwdDataM(FwdDataM),
    .NPC(NPC), .PCsrc(PCsrc), .Branch(Branch),
    .RS_D_OUT(RS_D_OUT), .RT_D_OUT(RT_D_OUT),
    .PauseF(PauseF), .PauseD(PauseD),
    .IRE(IRE), .PC4E(PC4E), .RSE(RSE), .RTE(RTE), .EXTE(EXTE)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic push_de(input logic [31:0] ire, input logic [31:0] pc4e,
                         input logic [31:0] rse, input logic [31:0] rte,
                         input logic [31:0] exte);
    de_t e;
    e.ire = ire; e.pc4e = pc4e; e.rse = rse; e.rte = rte; e.exte = exte;
    sbq.push_back(e);
  endtask

  task automatic push_bubble();
    push_de(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Clock one edge, then pop the expected D/E contents and compare.
  task automatic tick();
    de_t e;
    @(posedge Clk);
    #1;
    chk("sb_depth", sbq.size(), 1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("IRE", IRE, e.ire);
      chk("PC4E", PC4E, e.pc4e);
      chk("RSE", RSE, e.rse);
      chk("RTE", RTE, e.rte);
      chk("EXTE", EXTE, e.exte);
    end
  endtask

  task automatic hz_clear();
    RegWriteW = 1'b0; A3W = 5'd0; WDW = 32'd0;
    WriteRegE = 5'd0; TnewE = 2'd0;
    WriteRegM = 5'd0; TnewM = 2'd0; FwdDataM = 32'd0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    RegWriteW = 1'b1; A3W = a; WDW = d;
  endtask

  task automatic chk_ctl(input string tag, input logic [2:0] src, input logic br,
                         input logic [31:0] npc);
    chk({tag, "_pcsrc"}, {29'd0, PCsrc}, {29'd0, src});
    chk({tag, "_branch"}, {31'd0, Branch}, {31'd0, br});
    chk({tag, "_npc"}, NPC, npc);
  endtask

  task automatic chk_stall(input string tag, input logic s);
    chk({tag, "_pauseD"}, {31'd0, PauseD}, {31'd0, s});
    chk({tag, "_pauseF"}, {31'd0, PauseF}, {31'd0, s});
  endtask

  logic [4:0]  pre_a [4];
  logic [31:0] pre_d [4];

  initial begin
    pre_a[0] = 5'd2;  pre_d[0] = 32'h0000_0011;
    pre_a[1] = 5'd3;  pre_d[1] = 32'h0000_0055;
    pre_a[2] = 5'd4;  pre_d[2] = 32'h0000_0066;
    pre_a[3] = 5'd31; pre_d[3] = 32'h0000_3008;

    // Reset while a stall condition is present: stall still visible.
    Reset = 1'b1; hz_clear();
    IRD = enc_i(OP_BEQ, 5'd2, 5'd3, 16'd1); PC4D = 32'h3000;
    WriteRegE = 5'd2; TnewE = 2'd2;
    #1;
    chk_stall("rst_stall", 1'b1);
    push_bubble(); tick();

    // Last reset cycle collides with a write-back of $1.
    hz_clear(); wb(5'd1, 32'd7);
    IRD = enc_i(OP_ORI, 5'd0, 5'd1, 16'd7); PC4D = 32'h3004;
    #1;
    push_bubble(); tick();

    Reset = 1'b0; hz_clear();
    IRD = enc_r(5'd1, 5'd0, 5'd2, FN_ADDU); PC4D = 32'h3008;
    #1;
    chk("r1_after_rst", RS_D_OUT, 32'd0);
    push_de(IRD, 32'h3008, 32'd0, 32'd0, 32'd0); tick();

    // Preload registers under nops.
    for (int i = 0; i < 4; i++) begin
      hz_clear(); wb(pre_a[i], pre_d[i]);
      IRD = 32'd0; PC4D = 32'h3100 + 32'(4 * i);
      #1;
      push_de(32'd0, PC4D, 32'd0, 32'd0, 32'd0); tick();
    end

    // Write-through on rs, then the stored value read back through rt.
    hz_clear(); wb(5'd5, 32'h1234);
    IRD = enc_r(5'd5, 5'd0, 5'd1, FN_ADDU); PC4D = 32'h3200;
    #1;
    chk("wt_rs", RS_D_OUT, 32'h1234);
    push_de(IRD, 32'h3200, 32'h1234, 32'd0, 32'd0); tick();

    hz_clear();
    IRD = enc_r(5'd2, 5'd5, 5'd1, FN_SUBU); PC4D = 32'h3204;
    #1;
    chk("rf_rt5", RT_D_OUT, 32'h1234);
    push_de(IRD, 32'h3204, 32'h11, 32'h1234, 32'd0); tick();

    // $0 stays zero under write-back and forwarding, and never stalls.
    hz_clear(); wb(5'd0, 32'hFFFF);
    IRD = enc_r(5'd0, 5'd0, 5'd1, FN_ADDU); PC4D = 32'h3208;
    #1;
    chk("r0_wt", RS_D_OUT, 32'd0);
    push_de(IRD, 32'h3208, 32'd0, 32'd0, 32'd0); tick();

    hz_clear();
    #1;
    chk("r0_read", RS_D_OUT, 32'd0);
    push_de(IRD, 32'h3208, 32'd0, 32'd0, 32'd0); tick();

    hz_clear();
    IRD = enc_i(OP_BEQ, 5'd0, 5'd0, 16'd2); PC4D = 32'h3300;
    WriteRegE = 5'd0; TnewE = 2'd2; WriteRegM = 5'd0; TnewM = 2'd0; FwdDataM = 32'hDEAD;
    #1;
    chk_stall("r0_nostall", 1'b0);
    chk("r0_nofwd", RS_D_OUT, 32'd0);
    chk_ctl("beq_r0", 3'd1, 1'b1, 32'h3308);
    push_de(IRD, 32'h3300, 32'd0, 32'd0, 32'd2); tick();

    // Load-use on beq: E then M producer stall, then M forward resolves.
    hz_clear();
    IRD = enc_i(OP_BEQ, 5'd2, 5'd3, 16'd1); PC4D = 32'h3020;
    WriteRegE = 5'd2; TnewE = 2'd2;
    #1;
    chk_stall("lu_e", 1'b1);
    chk_ctl("lu_e", 3'd0, 1'b0, 32'd0);
    push_bubble(); tick();

    hz_clear(); WriteRegM = 5'd2; TnewM = 2'd1; FwdDataM = 32'h55;
    #1;
    chk_stall("lu_m1", 1'b1);
    push_bubble(); tick();

    hz_clear(); WriteRegM = 5'd2; TnewM = 2'd0; FwdDataM = 32'h55;
    #1;
    chk_stall("lu_fwd", 1'b0);
    chk("fwd_rs", RS_D_OUT, 32'h55);
    chk_ctl("lu_fwd", 3'd1, 1'b1, 32'h3024);
    push_de(IRD, 32'h3020, 32'h55, 32'h55, 32'd1); tick();

    // Tuse boundaries: ALU rs=1, addu rt=1, sw rt=2, jr rs=0.
    hz_clear();
    IRD = enc_r(5'd4, 5'd2, 5'd1, FN_ADDU); PC4D = 32'h3400;
    WriteRegE = 5'd4; TnewE = 2'd1;
    #1;
    chk_stall("alu_t1", 1'b0);
    push_de(IRD, 32'h3400, 32'h66, 32'h11, 32'd0); tick();

    TnewE = 2'd2;
    #1;
    chk_stall("alu_t2", 1'b1);
    push_bubble(); tick();

    hz_clear(); WriteRegM = 5'd2; TnewM = 2'd2;
    #1;
    chk_stall("addu_rt_m", 1'b1);
    push_bubble(); tick();

    hz_clear();
    IRD = enc_i(OP_SW, 5'd2, 5'd4, 16'd4); PC4D = 32'h3404;
    WriteRegE = 5'd4; TnewE = 2'd2;
    #1;
    chk_stall("sw_rt", 1'b0);
    push_de(IRD, 32'h3404, 32'h11, 32'h66, 32'd4); tick();

    hz_clear();
    IRD = enc_r(5'd31, 5'd0, 5'd0, FN_JR); PC4D = 32'h3050;
    WriteRegE = 5'd31; TnewE = 2'd1;
    #1;
    chk_stall("jr_stall", 1'b1);
    chk_ctl("jr_stall", 3'd0, 1'b0, 32'd0);
    push_bubble(); tick();

    hz_clear();
    #1;
    chk_ctl("jr", 3'd3, 1'b0, 32'h3008);
    push_de(IRD, 32'h3050, 32'h3008, 32'd0, 32'd0); tick();

    // Branch target arithmetic, taken/not taken, wrap-around.
    hz_clear();
    IRD = enc_i(OP_BEQ, 5'd4, 5'd4, 16'hFFFF); PC4D = 32'h3004;
    #1;
    chk_ctl("beq_tk", 3'd1, 1'b1, 32'h3000);
    push_de(IRD, 32'h3004, 32'h66, 32'h66, 32'hFFFF_FFFF); tick();

    IRD = enc_i(OP_BEQ, 5'd2, 5'd4, 16'hFFFF);
    #1;
    chk_ctl("beq_nt", 3'd1, 1'b0, 32'h3000);
    push_de(IRD, 32'h3004, 32'h11, 32'h66, 32'hFFFF_FFFF); tick();

    IRD = enc_i(OP_BEQ, 5'd3, 5'd3, 16'hFFFE); PC4D = 32'h4;
    #1;
    chk_ctl("beq_wrap", 3'd1, 1'b1, 32'hFFFF_FFFC);
    push_de(IRD, 32'h4, 32'h55, 32'h55, 32'hFFFF_FFFE); tick();

    // Jumps.
    IRD = enc_j(OP_J, 26'h0000C10); PC4D = 32'h3010;
    #1;
    chk_ctl("j", 3'd2, 1'b0, 32'h3040);
    push_de(IRD, 32'h3010, 32'd0, 32'd0, 32'd0); tick();

    IRD = enc_j(OP_JAL, 26'h3FFFFFF); PC4D = 32'hA000_0010;
    #1;
    chk_ctl("jal", 3'd2, 1'b0, 32'hAFFF_FFFC);
    push_de(IRD, 32'hA000_0010, 32'h3008, 32'h3008, 32'd0); tick();

    // Extension rules and an unsupported opcode.
    IRD = enc_i(OP_ORI, 5'd4, 5'd1, 16'h8001); PC4D = 32'h3500;
    #1;
    chk_ctl("ori", 3'd0, 1'b0, 32'd0);
    push_de(IRD, 32'h3500, 32'h66, 32'd0, 32'h0000_8001); tick();

    IRD = enc_i(OP_LUI, 5'd0, 5'd1, 16'h8001); PC4D = 32'h3504;
    #1;
    push_de(IRD, 32'h3504, 32'd0, 32'd0, 32'h8001_0000); tick();

    IRD = enc_i(OP_LW, 5'd4, 5'd1, 16'hFFF0); PC4D = 32'h3508;
    #1;
    chk_ctl("lw", 3'd0, 1'b0, 32'd0);
    push_de(IRD, 32'h3508, 32'h66, 32'd0, 32'hFFFF_FFF0); tick();

    IRD = {6'h3F, 5'd0, 5'd0, 16'h8001}; PC4D = 32'h350C;
    #1;
    chk_ctl("bad_op", 3'd0, 1'b0, 32'd0);
    push_de(IRD, 32'h350C, 32'd0, 32'd0, 32'd0); tick();

    chk("sb_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
